// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state, status codes and select decode for the PLL phase sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ROT,
        ST_GAP,
        ST_LOAD,
        ST_WAIT_LOCK,
        ST_FINISH
    } seq_state_t;

    localparam logic [1:0] STATUS_OK        = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT   = 2'b01;
    localparam logic [1:0] STATUS_LOCK_LOST = 2'b10;

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        sel_onehot = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/pll_seq_timer.sv
// rtl/pll_seq_timer.sv - loadable 16-bit down-counter with zero flag, shared by GAP and WAIT_LOCK
module pll_seq_timer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        dec_i,
    output logic        zero_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 16'd0)) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/pll_phase_sequencer.sv
// rtl/pll_phase_sequencer.sv - steps a PLL output phase N times, reloads it and waits for relock
module pll_phase_sequencer
    import pll_seq_pkg::*;
#(
    parameter int STEP_GAP     = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_OUT_SEL,
    input  logic       REQ_DIR,
    input  logic [7:0] REQ_STEPS,
    input  logic       PLL_LOCK,
    output logic       PHASE_ROTATE,
    output logic       PHASE_DIRECTION,
    output logic       PHASE_OUT0_SEL,
    output logic       PHASE_OUT1_SEL,
    output logic       PHASE_OUT2_SEL,
    output logic       PHASE_OUT3_SEL,
    output logic       LOAD_PHASE_N,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [1:0] STATUS,
    output logic [7:0] STEPS_DONE
);

    // Timer counts down to zero, so a load of K-1 gives K cycles in the timed state.
    localparam logic [15:0] GAP_LOAD  = 16'(STEP_GAP - 1);
    localparam logic [15:0] WAIT_LOAD = 16'(LOCK_TIMEOUT - 1);

    seq_state_t  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        dir_q, dir_d;
    logic [7:0]  steps_left_q, steps_left_d;
    logic [7:0]  steps_done_q, steps_done_d;
    logic [1:0]  status_q, status_d;

    logic        tmr_load;
    logic [15:0] tmr_load_val;
    logic        tmr_dec;
    logic        tmr_zero;

    pll_seq_timer u_timer (
        .clk_i      (CLK),
        .reset_i    (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign REQ_READY = (state_q == ST_IDLE) & PLL_LOCK & ~RESET;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        steps_left_d = steps_left_q;
        steps_done_d = steps_done_q;
        status_d     = status_q;
        tmr_load     = 1'b0;
        tmr_load_val = 16'd0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    sel_d        = REQ_OUT_SEL;
                    dir_d        = REQ_DIR;
                    steps_left_d = REQ_STEPS;
                    steps_done_d = 8'd0;
                    status_d     = STATUS_OK;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = (steps_left_q == 8'd0) ? ST_FINISH : ST_ROT;
            end
            ST_ROT: begin
                steps_left_d = steps_left_q - 8'd1;
                steps_done_d = steps_done_q + 8'd1;
                tmr_load     = 1'b1;
                tmr_load_val = GAP_LOAD;
                if (!PLL_LOCK) begin
                    status_d = STATUS_LOCK_LOST;
                    state_d  = ST_FINISH;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!PLL_LOCK) begin
                    status_d = STATUS_LOCK_LOST;
                    state_d  = ST_FINISH;
                end else if (tmr_zero) begin
                    state_d = (steps_left_q != 8'd0) ? ST_ROT : ST_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_LOAD: begin
                tmr_load     = 1'b1;
                tmr_load_val = WAIT_LOAD;
                state_d      = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (PLL_LOCK) begin
                    state_d = ST_FINISH;
                end else if (tmr_zero) begin
                    status_d = STATUS_TIMEOUT;
                    state_d  = ST_FINISH;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            sel_q        <= 2'd0;
            dir_q        <= 1'b0;
            steps_left_q <= 8'd0;
            steps_done_q <= 8'd0;
            status_q     <= STATUS_OK;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            steps_left_q <= steps_left_d;
            steps_done_q <= steps_done_d;
            status_q     <= status_d;
        end
    end

    // Selects and direction are presented from SETUP up to, but not including, FINISH.
    logic       sel_active;
    logic [3:0] sel_vec;

    assign sel_active = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign sel_vec    = sel_active ? sel_onehot(sel_q) : 4'b0000;

    assign PHASE_OUT0_SEL  = sel_vec[0];
    assign PHASE_OUT1_SEL  = sel_vec[1];
    assign PHASE_OUT2_SEL  = sel_vec[2];
    assign PHASE_OUT3_SEL  = sel_vec[3];
    assign PHASE_DIRECTION = sel_active & dir_q;
    assign PHASE_ROTATE    = (state_q == ST_ROT);
    assign LOAD_PHASE_N    = (state_q != ST_LOAD);
    assign BUSY            = (state_q != ST_IDLE);
    assign DONE            = (state_q == ST_FINISH) && (status_q == STATUS_OK);
    assign ERR             = (state_q == ST_FINISH) && (status_q != STATUS_OK);
    assign STATUS          = status_q;
    assign STEPS_DONE      = steps_done_q;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// tb/tb_pll_phase_sequencer.sv - self-checking bench for pll_phase_sequencer
module tb_pll_phase_sequencer;

    localparam int G = 4;
    localparam int T = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OUT_SEL;
    logic       REQ_DIR;
    logic [7:0] REQ_STEPS;
    logic       PLL_LOCK;
    logic       PHASE_ROTATE, PHASE_DIRECTION;
    logic       PHASE_OUT0_SEL, PHASE_OUT1_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL;
    logic       LOAD_PHASE_N, BUSY, DONE, ERR;
    logic [1:0] STATUS;
    logic [7:0] STEPS_DONE;

    always #5 CLK = ~CLK;

    pll_phase_sequencer #(.STEP_GAP(G), .LOCK_TIMEOUT(T)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ_VALID       (REQ_VALID),
        .REQ_READY       (REQ_READY),
        .REQ_OUT_SEL     (REQ_OUT_SEL),
        .REQ_DIR         (REQ_DIR),
        .REQ_STEPS       (REQ_STEPS),
        .PLL_LOCK        (PLL_LOCK),
        .PHASE_ROTATE    (PHASE_ROTATE),
        .PHASE_DIRECTION (PHASE_DIRECTION),
        .PHASE_OUT0_SEL  (PHASE_OUT0_SEL),
        .PHASE_OUT1_SEL  (PHASE_OUT1_SEL),
        .PHASE_OUT2_SEL  (PHASE_OUT2_SEL),
        .PHASE_OUT3_SEL  (PHASE_OUT3_SEL),
        .LOAD_PHASE_N    (LOAD_PHASE_N),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .ERR             (ERR),
        .STATUS          (STATUS),
        .STEPS_DONE      (STEPS_DONE)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] prev_status;
    logic [7:0] prev_steps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {busy, ready, rotate, load_n, dir, sel3..0, done, err, status, steps_done}
    function automatic logic [31:0] obs();
        return {11'd0, BUSY, REQ_READY, PHASE_ROTATE, LOAD_PHASE_N, PHASE_DIRECTION,
                PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT1_SEL, PHASE_OUT0_SEL,
                DONE, ERR, STATUS, STEPS_DONE};
    endfunction

    function automatic logic [31:0] pack(input logic busy, input logic ready, input logic rot,
                                         input logic loadn, input logic dir, input logic [3:0] sel,
                                         input logic done, input logic err, input logic [1:0] st,
                                         input logic [7:0] sd);
        return {11'd0, busy, ready, rot, loadn, dir, sel, done, err, st, sd};
    endfunction

    function automatic logic lock_at(input int c, input int drop, input int rise);
        return !(c >= drop && c < rise);
    endfunction

    // Cycle 0 is the accept cycle; PLL_LOCK is low in cycles [drop, rise).
    task automatic run_op(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                          input int drop, input int rise, input bit hold,
                          output int f_obs, output logic [1:0] st_obs, output logic [7:0] sd_obs);
        int per, finish, load_c, n_rot, step_end, abort_c;
        logic [1:0] st;
        per = 1 + G; load_c = -1; n_rot = 0; abort_c = -1;
        if (steps == 8'd0) begin
            finish = 2; st = 2'b00;
        end else begin
            step_end = 2 + int'(steps) * per;
            for (int c = 2; c < step_end; c++)
                if (abort_c < 0 && !lock_at(c, drop, rise)) abort_c = c;
            if (abort_c >= 0) begin
                finish = abort_c + 1; st = 2'b10; n_rot = (abort_c - 2) / per + 1;
            end else begin
                load_c = step_end; n_rot = int'(steps);
                finish = load_c + T + 1; st = 2'b01;
                for (int c = load_c + T; c > load_c; c--)
                    if (lock_at(c, drop, rise)) begin finish = c + 1; st = 2'b00; end
            end
        end
        f_obs = -1; st_obs = 2'b00; sd_obs = 8'd0;
        for (int c = 0; c <= finish + 1; c++) begin
            logic       lk, is_rot, mid, rdy;
            int         nd;
            logic [3:0] esel;
            logic [1:0] est;
            logic [7:0] esd;
            @(posedge CLK); #1;
            lk = lock_at(c, drop, rise);
            PLL_LOCK  = lk;
            REQ_VALID = hold || (c == 0);
            if (c == 0 || hold) begin
                REQ_OUT_SEL = sel; REQ_DIR = dir; REQ_STEPS = steps;
            end else begin
                REQ_OUT_SEL = 2'($urandom); REQ_DIR = 1'($urandom); REQ_STEPS = 8'($urandom);
            end
            is_rot = (c >= 2) && ((c - 2) % per == 0) && ((c - 2) / per < n_rot);
            nd = (c <= 2) ? 0 : ((c - 3) / per + 1);
            if (nd > n_rot) nd = n_rot;
            mid  = (c >= 1) && (c < finish);
            esel = mid ? (4'b0001 << sel) : 4'b0000;
            if (c == 0) begin est = prev_status; esd = prev_steps; end
            else if (c < finish) begin est = 2'b00; esd = 8'(nd); end
            else begin est = st; esd = 8'(nd); end
            rdy = (c == 0) ? 1'b1 : ((c > finish) ? lk : 1'b0);
            @(negedge CLK);
            chk($sformatf("cycle %0d of op sel=%0d steps=%0d", c, sel, steps), obs(),
                pack((c >= 1) && (c <= finish), rdy, is_rot, c != load_c, mid & dir, esel,
                     (c == finish) && (st == 2'b00), (c == finish) && (st != 2'b00), est, esd));
            if ((DONE || ERR) && f_obs < 0) begin
                f_obs = c; st_obs = STATUS; sd_obs = STEPS_DONE;
            end
        end
        prev_status = st;
        prev_steps  = 8'(n_rot);
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        logic [7:0] steps;
        int         drop;
        int         rise;
        int         exp_finish;
        logic [1:0] exp_status;
        logic [7:0] exp_steps;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[10];
        int         f;
        logic [1:0] so;
        logic [7:0] sdo;
        int         got;
        logic       any_pulse;

        tbl[0] = '{2'd2, 1'b1, 8'd3, 1000, 1000, 19, 2'b00, 8'd3};
        tbl[1] = '{2'd1, 1'b0, 8'd0, 1000, 1000,  2, 2'b00, 8'd0};
        tbl[2] = '{2'd0, 1'b1, 8'd1,    8,   40, 16, 2'b01, 8'd1};
        tbl[3] = '{2'd3, 1'b1, 8'd5,    9,   20, 10, 2'b10, 8'd2};
        tbl[4] = '{2'd1, 1'b1, 8'd4,    7,    9,  8, 2'b10, 8'd2};
        tbl[5] = '{2'd2, 1'b0, 8'd2,   13,   16, 17, 2'b00, 8'd2};
        tbl[6] = '{2'd0, 1'b0, 8'd1,    8,   15, 16, 2'b00, 8'd1};
        tbl[7] = '{2'd3, 1'b0, 8'd1,    7,    8,  9, 2'b00, 8'd1};
        tbl[8] = '{2'd2, 1'b1, 8'd3,    2,    3,  3, 2'b10, 8'd1};
        tbl[9] = '{2'd1, 1'b1, 8'd1,    1,    2,  9, 2'b00, 8'd1};

        RESET = 1'b1; REQ_VALID = 1'b0; REQ_OUT_SEL = 2'd0; REQ_DIR = 1'b0;
        REQ_STEPS = 8'd0; PLL_LOCK = 1'b1;
        prev_status = 2'b00; prev_steps = 8'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset state", obs(), pack(0, 0, 0, 1, 0, 4'b0, 0, 0, 2'b00, 8'd0));
        @(posedge CLK); #1 RESET = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].sel, tbl[i].dir, tbl[i].steps, tbl[i].drop, tbl[i].rise, 1'b0, f, so, sdo);
            chk($sformatf("vector %0d end cycle", i), f, tbl[i].exp_finish);
            chk($sformatf("vector %0d status", i), 32'(so), 32'(tbl[i].exp_status));
            chk($sformatf("vector %0d steps_done", i), 32'(sdo), 32'(tbl[i].exp_steps));
        end

        // Reset during the first ROT of a 4-step request.
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_OUT_SEL = 2'd1; REQ_DIR = 1'b1; REQ_STEPS = 8'd4; PLL_LOCK = 1'b1;
        @(negedge CLK);
        chk("reset seq accept ready", 32'(REQ_READY), 32'd1);
        @(posedge CLK); #1 REQ_VALID = 1'b0;
        @(posedge CLK); #1 RESET = 1'b1;
        @(negedge CLK);
        chk("reset seq rotate before reset", 32'(PHASE_ROTATE), 32'd1);
        chk("reset seq ready low in reset", 32'(REQ_READY), 32'd0);
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset seq outputs cleared", obs(), pack(0, 1, 0, 1, 0, 4'b0, 0, 0, 2'b00, 8'd0));
        any_pulse = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            any_pulse = any_pulse | DONE | ERR | BUSY;
        end
        chk("reset seq no done/err/busy afterwards", 32'(any_pulse), 32'd0);
        prev_status = 2'b00; prev_steps = 8'd0;
        run_op(2'd3, 1'b0, 8'd2, 1000, 1000, 1'b0, f, so, sdo);
        chk("post-reset request end cycle", f, 14);

        // REQ_VALID held through a whole operation; the repeat is taken right after FINISH.
        run_op(2'd0, 1'b1, 8'd2, 1000, 1000, 1'b1, f, so, sdo);
        got = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK); #1 REQ_VALID = 1'b0;
            @(negedge CLK);
            if (k == 0) chk("held valid second accept busy", 32'(BUSY), 32'd1);
            if (DONE && got < 0) got = k;
        end
        chk("held valid second done cycle", got, 13);
        prev_status = 2'b00; prev_steps = 8'd2;

        for (int i = 0; i < 40; i++) begin
            int d, r;
            if ($urandom_range(0, 2) == 0) d = 1000;
            else d = int'($urandom_range(1, 45));
            r = d + int'($urandom_range(1, 12));
            run_op(2'($urandom), 1'($urandom), 8'($urandom_range(0, 6)), d, r, 1'b0, f, so, sdo);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_phase_sequencer.md
PLL_PHASE_SEQUENCER -- requirements
Module: pll_phase_sequencer

Interface
REQ-001 SHALL have parameter STEP_GAP, default 4, meaning low cycles between PHASE_ROTATE pulses (legal range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, meaning maximum WAIT_LOCK cycles before error (legal range 1..65535).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port REQ_VALID, input, 1 bit: request valid.
REQ-006 SHALL have port REQ_READY, output, 1 bit: request accept.
REQ-007 SHALL have port REQ_OUT_SEL, input, 2 bits: target output 0..3.
REQ-008 SHALL have port REQ_DIR, input, 1 bit: phase direction (1 = advance).
REQ-009 SHALL have port REQ_STEPS, input, 8 bits: number of phase steps.
REQ-010 SHALL have port PLL_LOCK, input, 1 bit: PLL LOCK, already synchronous to CLK.
REQ-011 SHALL have ports PHASE_ROTATE, PHASE_DIRECTION, PHASE_OUT0_SEL, PHASE_OUT1_SEL, PHASE_OUT2_SEL and PHASE_OUT3_SEL, all outputs, 1 bit each: PLL phase controls.
REQ-012 SHALL have port LOAD_PHASE_N, output, 1 bit: active-low phase load strobe.
REQ-013 SHALL have port BUSY, output, 1 bit: operation in progress.
REQ-014 SHALL have ports DONE and ERR, outputs, 1 bit each: one-cycle completion pulses.
REQ-015 SHALL have port STATUS, output, 2 bits: 00 ok, 01 lock timeout, 10 lock lost while stepping; held until the next accept.
REQ-016 SHALL have port STEPS_DONE, output, 8 bits: count of rotate pulses issued in the current or last operation.

Function
REQ-017 SHALL implement states IDLE, SETUP, ROT, GAP, LOAD, WAIT_LOCK and FINISH.
REQ-018 SHALL drive REQ_READY = (state==IDLE) & PLL_LOCK & ~RESET; accept occurs when REQ_VALID & REQ_READY in cycle 0.
REQ-019 SHALL, on accept, capture sel/dir/steps, clear STATUS and STEPS_DONE, and enter SETUP in cycle 1.
REQ-020 SHALL, in SETUP, drive PHASE_DIRECTION=dir and PHASE_OUTn_SEL one-hot for sel, and hold both unchanged until FINISH.
REQ-021 SHALL, if steps==0, go SETUP->FINISH with no ROT or LOAD activity, giving DONE in cycle 2 with STATUS=00.
REQ-022 SHALL assert PHASE_ROTATE for exactly one cycle per ROT state, incrementing STEPS_DONE in that cycle.
REQ-023 SHALL follow each ROT with GAP for STEP_GAP cycles (PHASE_ROTATE=0); after GAP, go to ROT if steps remain, else LOAD.
REQ-024 SHALL place the first ROT in cycle 2 and LOAD in cycle 2+N*(1+STEP_GAP).
REQ-025 SHALL drive LOAD_PHASE_N=0 for exactly the one LOAD cycle, then enter WAIT_LOCK.
REQ-026 SHALL, in WAIT_LOCK, count cycles; PLL_LOCK=1 -> FINISH with STATUS=00; count reaching LOCK_TIMEOUT with PLL_LOCK=0 -> FINISH with STATUS=01.
REQ-027 SHALL, if PLL_LOCK=0 in any ROT or GAP cycle, abort to FINISH next cycle with no further ROT, no LOAD and STATUS=10.
REQ-028 SHALL, in FINISH (one cycle), pulse DONE if STATUS=00 else ERR, deassert all PHASE_OUTn_SEL and PHASE_DIRECTION, then return to IDLE.
REQ-029 SHALL hold BUSY=1 in every state except IDLE; DONE and ERR are never both high.
REQ-030 SHALL accept no new request until IDLE is re-entered (earliest accept is the cycle after FINISH).

Reset
REQ-031 SHALL, when RESET is high at a clock edge, including mid-operation, enter IDLE with PHASE_ROTATE=0, LOAD_PHASE_N=1, PHASE_DIRECTION=0, all PHASE_OUTn_SEL=0, BUSY=0, DONE=0, ERR=0, STATUS=00, STEPS_DONE=0 and all counters cleared.
REQ-032 SHALL emit no DONE or ERR for an operation aborted by RESET.

Structure
REQ-033 SHALL place the state enum, STATUS code constants and the one-hot select decode function in shared package pll_seq_pkg.
REQ-034 SHALL use a single sub-module pll_seq_timer (loadable 16-bit down-counter with zero flag) for both the GAP and WAIT_LOCK timing.

Verification
REQ-035 SHALL show: STEP_GAP=4, request sel=2, dir=1, steps=3, PLL_LOCK held 1 -> ROT in cycles 2/7/12, LOAD_PHASE_N low in cycle 17, DONE in cycle 19, STATUS=00, STEPS_DONE=3, only PHASE_OUT2_SEL high.
REQ-036 SHALL show: steps=0 -> no PHASE_ROTATE, LOAD_PHASE_N stays 1, DONE in cycle 2.
REQ-037 SHALL show: LOCK_TIMEOUT=8, PLL_LOCK forced 0 after LOAD -> ERR exactly 8 WAIT_LOCK cycles later, STATUS=01.
REQ-038 SHALL show: steps=5, PLL_LOCK dropped during the 2nd GAP -> ERR next cycle, STEPS_DONE=2, no LOAD pulse, STATUS=10.
REQ-039 SHALL show: RESET asserted during ROT of a steps=4 request -> next cycle all outputs at reset values, no DONE or ERR, and a new request accepted after release.
REQ-040 SHALL show: REQ_VALID held high during BUSY -> REQ_READY=0 throughout, and a second request accepted in the cycle after FINISH.
